// File: rtl/mac_array_pipe.sv
// N-lane MAC with a 3-stage valid/ready pipeline: operand register, lane products,
// adder tree plus partial sum (external or self-accumulated) with saturate/wrap reduction.
module mac_array_pipe #(
    parameter int LANES   = 4,
    parameter int BW      = 4,
    parameter int PSUM_BW = 16,
    parameter int SAT_EN  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*BW-1:0]   a_in,
    input  logic [LANES*BW-1:0]   b_in,
    input  logic [PSUM_BW-1:0]    c_in,
    input  logic                  acc_sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PSUM_BW-1:0]    out,
    output logic                  sat_flag
);

    localparam int PW = 2*BW + 1;
    localparam int WW = PSUM_BW + 2;
    localparam logic [WW-1:0] SAT_MAX = {3'b000, {(PSUM_BW-1){1'b1}}};
    localparam logic [WW-1:0] SAT_MIN = {3'b111, {(PSUM_BW-1){1'b0}}};

    logic                       r_v1, r_v2, r_v3;
    logic [LANES-1:0][BW-1:0]   r_a1, r_b1;
    logic [PSUM_BW-1:0]         r_c1, r_c2;
    logic                       r_acc1, r_acc2;
    logic [LANES-1:0][PW-1:0]   r_p2;
    logic [PSUM_BW-1:0]         r_out;
    logic                       r_sat;

    logic                       w_adv;
    logic [LANES-1:0][PW-1:0]   w_prod;
    logic [WW-1:0]              w_tree [2*LANES];
    logic [PSUM_BW-1:0]         w_addend;
    logic [WW-1:0]              w_total;
    logic [PSUM_BW-1:0]         w_res;
    logic                       w_sat;

    // The whole pipeline moves as one; a full stage 3 that cannot drain freezes everything.
    assign w_adv     = !r_v3 || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_v3;
    assign out       = r_out;
    assign sat_flag  = r_sat;

    // Stage 1: operand capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v1   <= 1'b0;
            r_a1   <= '0;
            r_b1   <= '0;
            r_c1   <= '0;
            r_acc1 <= 1'b0;
        end else if (w_adv) begin
            // NOTE: non-blocking so every stage samples the previous cycle's values.
            r_v1   <= in_valid;
            r_a1   <= a_in;
            r_b1   <= b_in;
            r_c1   <= c_in;
            r_acc1 <= acc_sel;
        end
    end

    // Unsigned activation times signed weight, both extended to the full product width.
    always_comb begin
        // NOTE: default first so no path through the block leaves a latch.
        w_prod = '0;
        for (int i = 0; i < LANES; i++) begin
            w_prod[i] = $signed({{(BW+1){1'b0}}, r_a1[i]}) *
                        $signed({{(BW+1){r_b1[i][BW-1]}}, r_b1[i]});
        end
    end

    // Stage 2: products, with the partial-sum operand carried alongside.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v2   <= 1'b0;
            r_p2   <= '0;
            r_c2   <= '0;
            r_acc2 <= 1'b0;
        end else if (w_adv) begin
            r_v2   <= r_v1;
            r_p2   <= w_prod;
            r_c2   <= r_c1;
            r_acc2 <= r_acc1;
        end
    end

    // Binary adder tree in heap order: leaves at LANES..2*LANES-1, root at index 1.
    always_comb begin
        for (int k = 0; k < 2*LANES; k++) w_tree[k] = '0;
        for (int i = 0; i < LANES; i++) begin
            w_tree[LANES+i] = {{(WW-PW){r_p2[i][PW-1]}}, r_p2[i]};
        end
        for (int k = LANES-1; k >= 1; k--) begin
            w_tree[k] = w_tree[2*k] + w_tree[2*k+1];
        end
    end

    // Self-accumulate reads the live out register, so consecutive chained beats need no bubble.
    assign w_addend = r_acc2 ? r_out : r_c2;
    assign w_total  = w_tree[1] + {{2{w_addend[PSUM_BW-1]}}, w_addend};

    always_comb begin
        w_res = w_total[PSUM_BW-1:0];
        w_sat = 1'b0;
        if (SAT_EN != 0) begin
            if ($signed(w_total) > $signed(SAT_MAX)) begin
                w_res = SAT_MAX[PSUM_BW-1:0];
                w_sat = 1'b1;
            end else if ($signed(w_total) < $signed(SAT_MIN)) begin
                w_res = SAT_MIN[PSUM_BW-1:0];
                w_sat = 1'b1;
            end
        end else begin
            w_sat = (w_total != {{2{w_total[PSUM_BW-1]}}, w_total[PSUM_BW-1:0]});
        end
    end

    // Stage 3: bubbles leave out/sat_flag untouched and only drop the valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v3  <= 1'b0;
            r_out <= '0;
            r_sat <= 1'b0;
        end else if (w_adv) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_out <= w_res;
                r_sat <= w_sat;
            end
        end
    end

endmodule

// File: tb/tb_mac_array_pipe.sv
// Directed bench for mac_array_pipe: a saturating and a wrapping instance share stimulus;
// table vectors for single beats, then accumulate-chain, backpressure and reset sequences.
module tb_mac_array_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] a_in, b_in, c_in;
    logic        acc_sel;
    logic        out_ready;

    logic        in_ready, out_valid, sat_flag;
    logic [15:0] out;
    logic        w_in_ready, w_out_valid, w_sat_flag;
    logic [15:0] w_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mac_array_pipe #(.LANES(4), .BW(4), .PSUM_BW(16), .SAT_EN(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .acc_sel(acc_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .sat_flag(sat_flag)
    );

    mac_array_pipe #(.LANES(4), .BW(4), .PSUM_BW(16), .SAT_EN(0)) dut_wrap (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .acc_sel(acc_sel),
        .out_valid(w_out_valid), .out_ready(out_ready), .out(w_out), .sat_flag(w_sat_flag)
    );

    typedef struct {
        string       name;
        logic [15:0] a;        // lane 0 in the low nibble
        logic [15:0] b;
        logic [15:0] c;
        logic        acc;
        logic [15:0] exp_out;  // SAT_EN=1 instance
        logic        exp_sat;
        logic [15:0] exp_wout; // SAT_EN=0 instance
        logic        exp_wsat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One isolated beat: transfer, bounded wait for out_valid, latency and value checks.
    task automatic apply_beat(input vec_t v);
        int cyc;
        check({v.name, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a_in     = v.a;
        b_in     = v.b;
        c_in     = v.c;
        acc_sel  = v.acc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        acc_sel  = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({v.name, " latency"},  32'(cyc),         32'd3);
        check({v.name, " out"},      32'(out),         32'(v.exp_out));
        check({v.name, " sat"},      32'(sat_flag),    32'(v.exp_sat));
        check({v.name, " wrap vld"}, 32'(w_out_valid), 32'd1);
        check({v.name, " wrap out"}, 32'(w_out),       32'(v.exp_wout));
        check({v.name, " wrap sat"}, 32'(w_sat_flag),  32'(v.exp_wsat));
        @(posedge clk); #1;
        check({v.name, " vld drop"}, 32'(out_valid),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          got_cyc[$];
        logic [15:0] got_val[$];
        logic [15:0] rx[$];
        int          bi;
        int          stall_left;
        int          vcount;
        logic        accept;

        // 32760 + 4*105 = 33180 -> clamps to 32767, wraps to 33180-65536 = 16'h819C.
        // -32768 + 4*(-120) = -33248 -> clamps to 16'h8000, wraps to 32288 = 16'h7E20.
        vecs[0] = '{"basic",     16'h4321, 16'h1111, 16'd10,   1'b0, 16'h0014, 1'b0, 16'h0014, 1'b0};
        vecs[1] = '{"signed",    16'hFFFF, 16'hFFFF, 16'd0,    1'b0, 16'hFFC4, 1'b0, 16'hFFC4, 1'b0};
        vecs[2] = '{"mixed",     16'h9753, 16'hF1D2, 16'd100,  1'b0, 16'h0059, 1'b0, 16'h0059, 1'b0};
        vecs[3] = '{"wmin",      16'h000F, 16'h0008, 16'd0,    1'b0, 16'hFF88, 1'b0, 16'hFF88, 1'b0};
        vecs[4] = '{"sat_pos",   16'hFFFF, 16'h7777, 16'h7FF8, 1'b0, 16'h7FFF, 1'b1, 16'h819C, 1'b1};
        vecs[5] = '{"sat_neg",   16'hFFFF, 16'h8888, 16'h8000, 1'b0, 16'h8000, 1'b1, 16'h7E20, 1'b1};
        vecs[6] = '{"zero",      16'h0000, 16'h0000, 16'd1234, 1'b0, 16'h04D2, 1'b0, 16'h04D2, 1'b0};
        vecs[7] = '{"zero_acc",  16'h0000, 16'h0000, 16'd999,  1'b1, 16'h04D2, 1'b0, 16'h04D2, 1'b0};

        reset     = 1'b0;
        in_valid  = 1'b0;
        a_in      = '0;
        b_in      = '0;
        c_in      = '0;
        acc_sel   = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out",       32'(out),       32'd0);
        check("rst sat",       32'(sat_flag),  32'd0);
        check("rst in_ready",  32'(in_ready),  32'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) apply_beat(vecs[i]);

        // Accumulate chain: 13, 21, 29, 37 on consecutive cycles.
        for (int i = 0; i < 10; i++) begin
            if (out_valid) begin
                got_cyc.push_back(i);
                got_val.push_back(out);
            end
            if (i < 4) begin
                in_valid = 1'b1;
                a_in     = 16'h1111;
                b_in     = 16'h2222;
                c_in     = 16'd5;
                acc_sel  = (i != 0);
            end else begin
                in_valid = 1'b0;
                acc_sel  = 1'b0;
            end
            @(posedge clk); #1;
        end
        check("chain count", 32'(got_val.size()), 32'd4);
        for (int k = 0; k < got_val.size() && k < 4; k++) begin
            check($sformatf("chain out%0d", k), 32'(got_val[k]), 32'(13 + 8*k));
            check($sformatf("chain cyc%0d", k), 32'(got_cyc[k]), 32'(3 + k));
        end

        // Backpressure: six beats c=1..6, out_ready low for 5 cycles from the first out_valid.
        bi         = 0;
        stall_left = -1;
        for (int it = 0; it < 40 && rx.size() < 6; it++) begin
            if (out_valid && stall_left < 0) stall_left = 5;
            out_ready = !(stall_left > 0);
            if (bi < 6) begin
                in_valid = 1'b1;
                a_in     = '0;
                b_in     = '0;
                c_in     = 16'(bi + 1);
                acc_sel  = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stall_left > 0) begin
                check("bp in_ready low", 32'(in_ready), 32'd0);
                check("bp out hold",     32'(out),      32'd1);
                stall_left--;
            end
            if (out_valid && out_ready) rx.push_back(out);
            accept = in_valid && in_ready;
            @(posedge clk); #1;
            if (accept) bi++;
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        check("bp stall seen", 32'(stall_left), 32'd0);
        check("bp count", 32'(rx.size()), 32'd6);
        for (int k = 0; k < rx.size() && k < 6; k++) begin
            check($sformatf("bp out%0d", k), 32'(rx[k]), 32'(k + 1));
        end
        repeat (3) @(posedge clk);
        #1;

        // Reset with two beats in flight: nothing may emerge afterwards.
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            a_in     = '0;
            b_in     = '0;
            c_in     = 16'(3 + i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst out",       32'(out),       32'd0);
        check("midrst sat",       32'(sat_flag),  32'd0);
        check("midrst wrap out",  32'(w_out),     32'd0);
        @(posedge clk); #1;
        reset  = 1'b1;
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) vcount++;
        end
        check("midrst no result", 32'(vcount), 32'd0);
        apply_beat('{"post_rst", 16'h0000, 16'h0000, 16'd7, 1'b0, 16'h0007, 1'b0, 16'h0007, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
